// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response channel bundle for the memory protocol.
//               The master modport is the client side (load/store unit). The
//               slave modport is the responder side (mem_responder).
//   Request  : req_val, req_rdy, req_op, req_opaque, req_addr, req_len, req_data
//   Response : resp_val, resp_rdy, resp_op, resp_opaque, resp_len, resp_data
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if #(
  parameter int p_opaque_bits = 8
);
  logic                     req_val;
  logic                     req_rdy;
  logic                     req_op;
  logic [p_opaque_bits-1:0] req_opaque;
  logic [31:0]              req_addr;
  logic [1:0]               req_len;
  logic [31:0]              req_data;

  logic                     resp_val;
  logic                     resp_rdy;
  logic                     resp_op;
  logic [p_opaque_bits-1:0] resp_opaque;
  logic [1:0]               resp_len;
  logic [31:0]              resp_data;

  modport master (
    output req_val, req_op, req_opaque, req_addr, req_len, req_data, resp_rdy,
    input  req_rdy, resp_val, resp_op, resp_opaque, resp_len, resp_data
  );

  modport slave (
    input  req_val, req_op, req_opaque, req_addr, req_len, req_data, resp_rdy,
    output req_rdy, resp_val, resp_op, resp_opaque, resp_len, resp_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory server at the responder end of the val/rdy memory
//               protocol. Requests are applied to an internal 32-bit word
//               array at acceptance; responses come back in order after a
//               fixed latency through a small circular response buffer.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - mem_responder_if.slave (request and response channels)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int p_depth_bits  = 8,   // log2 of word count
  parameter int p_latency     = 1,   // 1..15
  parameter int p_num_entries = 4,   // 2..16, power of two
  parameter int p_opaque_bits = 8
) (
  input wire              clk,
  input wire              rst,
  mem_responder_if.slave  bus
);

  localparam int c_words = 1 << p_depth_bits;
  localparam int c_ptr_w = $clog2(p_num_entries);
  localparam int c_cnt_w = c_ptr_w + 1;

  // Word array: deliberately never reset so contents survive rst.
  logic [31:0]              r_mem [c_words];

  // Response buffer payload and per-entry latency countdown.
  logic                     r_ent_op     [p_num_entries];
  logic [p_opaque_bits-1:0] r_ent_opaque [p_num_entries];
  logic [1:0]               r_ent_len    [p_num_entries];
  logic [31:0]              r_ent_data   [p_num_entries];
  logic [3:0]               r_ent_delay  [p_num_entries];

  logic [c_ptr_w-1:0]       r_head;
  logic [c_ptr_w-1:0]       r_tail;
  logic [c_cnt_w-1:0]       r_count;

  logic [p_depth_bits-1:0]  w_idx;
  logic [31:0]              w_word;
  logic [31:0]              w_rd_lane;
  logic [31:0]              w_wr_word;
  logic                     w_req_rdy;
  logic                     w_req_fire;
  logic                     w_resp_val;
  logic                     w_resp_fire;
  logic                     w_unused_addr;

  // Address bits above the array are ignored, so the array aliases.
  assign w_idx         = bus.req_addr[p_depth_bits+1:2];
  assign w_unused_addr = ^bus.req_addr[31:p_depth_bits+2];
  assign w_word        = r_mem[w_idx];

  // No bypass when full: a same-cycle dequeue does not open the request port.
  assign w_req_rdy   = !rst && (r_count < c_cnt_w'(p_num_entries));
  assign w_req_fire  = bus.req_val && w_req_rdy;
  assign w_resp_val  = !rst && (r_count != '0) && (r_ent_delay[r_head] == 4'd0);
  assign w_resp_fire = w_resp_val && bus.resp_rdy;

  // Lane extraction for reads; len 3 behaves as a word access.
  always_comb begin
    w_rd_lane = w_word;
    case (bus.req_len)
      2'd1:    w_rd_lane = {24'd0, w_word[{bus.req_addr[1:0], 3'b000} +: 8]};
      2'd2:    w_rd_lane = {16'd0, w_word[{bus.req_addr[1], 4'b0000} +: 16]};
      default: w_rd_lane = w_word;
    endcase
  end

  // Merge write data into the current word (read-modify-write in one cycle).
  always_comb begin
    w_wr_word = w_word;
    case (bus.req_len)
      2'd1:    w_wr_word[{bus.req_addr[1:0], 3'b000} +: 8]  = bus.req_data[7:0];
      2'd2:    w_wr_word[{bus.req_addr[1], 4'b0000} +: 16]  = bus.req_data[15:0];
      default: w_wr_word = bus.req_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_req_fire && bus.req_op) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  // Payload is captured at acceptance; reads therefore see every earlier write.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_ent_op[r_tail]     <= bus.req_op;
      r_ent_opaque[r_tail] <= bus.req_opaque;
      r_ent_len[r_tail]    <= bus.req_len;
      r_ent_data[r_tail]   <= bus.req_op ? 32'd0 : w_rd_lane;
    end
  end

  // Countdowns keep running while the head is stalled, so entries behind a
  // stalled head are already due when it finally leaves.
  for (genvar gi = 0; gi < p_num_entries; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        r_ent_delay[gi] <= 4'd0;
      end else if (w_req_fire && (r_tail == c_ptr_w'(gi))) begin
        r_ent_delay[gi] <= 4'(p_latency - 1);
      end else if (r_ent_delay[gi] != 4'd0) begin
        r_ent_delay[gi] <= r_ent_delay[gi] - 4'd1;
      end
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_req_fire) begin
        r_tail <= r_tail + c_ptr_w'(1);
      end
      if (w_resp_fire) begin
        r_head <= r_head + c_ptr_w'(1);
      end
      case ({w_req_fire, w_resp_fire})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.req_rdy     = w_req_rdy;
  assign bus.resp_val    = w_resp_val;
  assign bus.resp_op     = w_resp_val && r_ent_op[r_head];
  assign bus.resp_opaque = w_resp_val ? r_ent_opaque[r_head] : '0;
  assign bus.resp_len    = w_resp_val ? r_ent_len[r_head]    : 2'd0;
  assign bus.resp_data   = w_resp_val ? r_ent_data[r_head]   : 32'd0;

endmodule
`default_nettype wire
